// File: rtl/id_arb_if.sv
// -----------------------------------------------------------------------------
// id_arb_if
// Bundle of the two character sources, the forwarded-character stream and the
// token/identifier reporting outputs used by id_arbiter.
//   master modport : drives the two sources, observes everything else
//   slave  modport : the arbiter side (accepts sources, drives results)
// Parameter CNT_W sets the width of the per-source identifier counters.
// -----------------------------------------------------------------------------
interface id_arb_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic [7:0]       req0_char;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_char;
    logic             req1_ready;
    logic             out_valid;
    logic [7:0]       out_char;
    logic             out_src;
    logic             tok_done;
    logic             tok_is_id;
    logic             tok_src;
    logic [CNT_W-1:0] id_cnt0;
    logic [CNT_W-1:0] id_cnt1;

    modport master (
        output req0_valid, req0_char, req1_valid, req1_char,
        input  req0_ready, req1_ready, out_valid, out_char, out_src,
        input  tok_done, tok_is_id, tok_src, id_cnt0, id_cnt1
    );

    modport slave (
        input  req0_valid, req0_char, req1_valid, req1_char,
        output req0_ready, req1_ready, out_valid, out_char, out_src,
        output tok_done, tok_is_id, tok_src, id_cnt0, id_cnt1
    );
endinterface

// File: rtl/id_arbiter.sv
// -----------------------------------------------------------------------------
// id_arbiter
// Arbitrates two ASCII character sources. A granted source keeps the grant
// until it delivers a delimiter, so a token is never interleaved with the other
// source. Every accepted character is forwarded one cycle later; tokens
// (runs of letters/digits) are reported when their closing delimiter is
// forwarded, and tokens starting with a letter are counted per source.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : id_arb_if.slave (sources, forwarded stream, token reports, counters)
// Parameters: CNT_W counter width, TMO_CYC watchdog limit.
// Optional feature: define ID_ARB_TIMEOUT_EN to add a watchdog that releases a
// grant after TMO_CYC consecutive idle cycles of the granted source.
// -----------------------------------------------------------------------------
module id_arbiter #(
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 16
) (
    input  logic      clk,
    input  logic      reset,
    id_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic             last_grant_r, last_grant_next_s;
    logic             granted_s, sel_src_s, sel_valid_s, accept_s, tmo_s;
    logic [7:0]       sel_char_s;
    logic             is_letter_s, is_delim_s;
    logic             len_nz_r, first_letter_r;
    logic             ready0_r, ready1_r;
    logic             out_valid_r, out_src_r;
    logic [7:0]       out_char_r;
    logic             tok_done_r, tok_is_id_r, tok_src_r;
    logic [CNT_W-1:0] cnt0_r, cnt1_r;

    function automatic logic f_is_letter(input logic [7:0] c);
        return ((c >= 8'd65) && (c <= 8'd90)) || ((c >= 8'd97) && (c <= 8'd122));
    endfunction

    function automatic logic f_is_digit(input logic [7:0] c);
        return (c >= 8'd48) && (c <= 8'd57);
    endfunction

    assign granted_s   = (state_r == GRANT0) || (state_r == GRANT1);
    assign sel_src_s   = (state_r == GRANT1);
    assign sel_valid_s = sel_src_s ? bus.req1_valid : bus.req0_valid;
    assign sel_char_s  = sel_src_s ? bus.req1_char  : bus.req0_char;
    assign accept_s    = granted_s && sel_valid_s;
    assign is_letter_s = f_is_letter(sel_char_s);
    assign is_delim_s  = !is_letter_s && !f_is_digit(sel_char_s);

`ifdef ID_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TMO_CYC + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Watchdog: counts consecutive idle cycles of the granted source
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= '0;
        end else if (!granted_s || accept_s || (state_next_s != state_r)) begin
            wd_cnt_r <= '0;
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end

    // The TMO_CYC-th idle cycle forces the release
    assign tmo_s = granted_s && !sel_valid_s && (wd_cnt_r == WD_W'(TMO_CYC - 1));
`else
    assign tmo_s = 1'b0;
`endif

    // Next-state logic: grant selection in IDLE, release on delimiter or timeout
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    state_next_s = last_grant_r ? GRANT0 : GRANT1;
                end else if (bus.req0_valid) begin
                    state_next_s = GRANT0;
                end else if (bus.req1_valid) begin
                    state_next_s = GRANT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if ((accept_s && is_delim_s) || tmo_s) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = sel_src_s;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, grant history, ready decode and forwarded-character registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            ready0_r     <= 1'b0;
            ready1_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_char_r   <= 8'h00;
            out_src_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
            ready0_r     <= (state_next_s == GRANT0);
            ready1_r     <= (state_next_s == GRANT1);
            out_valid_r  <= accept_s;
            if (accept_s) begin
                out_char_r <= sel_char_s;
                out_src_r  <= sel_src_s;
            end
        end
    end

    // Token tracking, token report and saturating identifier counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_nz_r       <= 1'b0;
            first_letter_r <= 1'b0;
            tok_done_r     <= 1'b0;
            tok_is_id_r    <= 1'b0;
            tok_src_r      <= 1'b0;
            cnt0_r         <= '0;
            cnt1_r         <= '0;
        end else begin
            tok_done_r <= 1'b0;
            if (accept_s && !is_delim_s) begin
                if (!len_nz_r) begin
                    first_letter_r <= is_letter_s;
                end
                len_nz_r <= 1'b1;
            end else if (accept_s) begin
                if (len_nz_r) begin
                    tok_done_r  <= 1'b1;
                    tok_is_id_r <= first_letter_r;
                    tok_src_r   <= sel_src_s;
                    if (first_letter_r && sel_src_s && (cnt1_r != {CNT_W{1'b1}})) begin
                        cnt1_r <= cnt1_r + CNT_W'(1);
                    end else if (first_letter_r && !sel_src_s && (cnt0_r != {CNT_W{1'b1}})) begin
                        cnt0_r <= cnt0_r + CNT_W'(1);
                    end
                end
                len_nz_r       <= 1'b0;
                first_letter_r <= 1'b0;
            end else if (state_next_s != state_r) begin
                // grant released without a delimiter (watchdog): abort token
                len_nz_r       <= 1'b0;
                first_letter_r <= 1'b0;
            end else begin
                len_nz_r       <= len_nz_r;
                first_letter_r <= first_letter_r;
            end
        end
    end

    assign bus.req0_ready = ready0_r;
    assign bus.req1_ready = ready1_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_char   = out_char_r;
    assign bus.out_src    = out_src_r;
    assign bus.tok_done   = tok_done_r;
    assign bus.tok_is_id  = tok_is_id_r;
    assign bus.tok_src    = tok_src_r;
    assign bus.id_cnt0    = cnt0_r;
    assign bus.id_cnt1    = cnt1_r;
endmodule

// File: tb/tb_id_arbiter.sv
// -----------------------------------------------------------------------------
// tb_id_arbiter
// Directed bench for id_arbiter: a per-cycle vector table for the basic token
// and arbitration behaviour, then hand-written sequences for counter
// saturation, simultaneous requests, the idle-source watchdog and reset
// during a token. Counters are instantiated 2 bits wide so saturation is
// reachable quickly.
// -----------------------------------------------------------------------------
module tb_id_arbiter;
    localparam int CNT_W   = 2;
    localparam int TMO_CYC = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_arb_if #(.CNT_W(CNT_W)) bus ();

    id_arbiter #(.CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] c0;
        logic       v1;
        logic [7:0] c1;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] oc;
        logic       os;
        logic       td;
        logic       tid;
        logic       ts;
        logic [1:0] n0;
        logic [1:0] n1;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_char  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_char  = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one character on a source and hold it until it is accepted
    task automatic xfer(input int src, input logic [7:0] ch);
        logic done;
        done = 1'b0;
        if (src == 0) begin
            bus.req0_valid = 1'b1; bus.req0_char = ch;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_char = ch;
        end
        for (int n = 0; n < 40 && !done; n++) begin
            done = (src == 0) ? bus.req0_ready : bus.req1_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("xfer_timeout", 32'd0, 32'd1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ab [3];
        int p0, p1, cyc, nout, td_seen, first_r1;
        logic [7:0] oc_q [$];
        logic       os_q [$];
        int         cy_q [$];
        logic       r0s, r1s;

        checks = 0;
        errors = 0;
        ab[0] = 8'h61; ab[1] = 8'h62; ab[2] = 8'h20;

        //            v0    c0     v1    c1     r0    r1    ov    oc     os    td    tid   ts    n0     n1
        vecs[0]  = '{1'b1, 8'h61, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 8'h61, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{1'b1, 8'h31, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[3]  = '{1'b1, 8'h62, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[4]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h39, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h39, 1'b0, 1'b1, 1'b1, 8'h39, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h2c, 1'b0, 1'b1, 1'b1, 8'h2c, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[9]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h2c, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[10] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[11] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[12] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};

        // ---- reset values ----
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_char = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_char = 8'h00;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_char",  32'(bus.out_char),  32'd0);
        chk("rst_tok_done",  32'(bus.tok_done),  32'd0);
        chk("rst_tok_is_id", 32'(bus.tok_is_id), 32'd0);
        chk("rst_ready",     32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("rst_cnt",       32'({bus.id_cnt0, bus.id_cnt1}), 32'd0);
        do_reset();

        // ---- table: "a1b ", "9x,", "  " ----
        for (int i = 0; i < 14; i++) begin
            bus.req0_valid = vecs[i].v0; bus.req0_char = vecs[i].c0;
            bus.req1_valid = vecs[i].v1; bus.req1_char = vecs[i].c1;
            chk($sformatf("v%0d ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d out_char", i),  32'(bus.out_char),  32'(vecs[i].oc));
            chk($sformatf("v%0d out_src", i),   32'(bus.out_src),   32'(vecs[i].os));
            chk($sformatf("v%0d tok_done", i),  32'(bus.tok_done),  32'(vecs[i].td));
            chk($sformatf("v%0d tok_is_id", i), 32'(bus.tok_is_id), 32'(vecs[i].tid));
            chk($sformatf("v%0d tok_src", i),   32'(bus.tok_src),   32'(vecs[i].ts));
            chk($sformatf("v%0d id_cnt0", i),   32'(bus.id_cnt0),   32'(vecs[i].n0));
            chk($sformatf("v%0d id_cnt1", i),   32'(bus.id_cnt1),   32'(vecs[i].n1));
        end

        // ---- saturation of the 2-bit counter (starts at 1) ----
        for (int k = 0; k < 4; k++) begin
            xfer(0, 8'h61);
            xfer(0, 8'h20);
            if (k == 0) chk("sat_step", 32'(bus.id_cnt0), 32'd2);
        end
        chk("sat_cnt0", 32'(bus.id_cnt0), 32'd3);
        chk("sat_cnt1", 32'(bus.id_cnt1), 32'd0);

        // ---- both sources request "ab " from reset ----
        do_reset();
        p0 = 0; p1 = 0; td_seen = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            bus.req0_valid = (p0 < 3); bus.req0_char = (p0 < 3) ? ab[p0] : 8'h00;
            bus.req1_valid = (p1 < 3); bus.req1_char = (p1 < 3) ? ab[p1] : 8'h00;
            r0s = bus.req0_ready; r1s = bus.req1_ready;
            @(posedge clk);
            #1;
            if (bus.req0_valid && r0s) p0++;
            if (bus.req1_valid && r1s) p1++;
            if (bus.out_valid) begin
                oc_q.push_back(bus.out_char); os_q.push_back(bus.out_src); cy_q.push_back(cyc);
            end
            if (bus.tok_done) td_seen++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        nout = oc_q.size();
        chk("both_nout", 32'(nout), 32'd6);
        if (nout == 6) begin
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("both_char%0d", j), 32'(oc_q[j]), 32'(ab[j % 3]));
                chk($sformatf("both_src%0d", j),  32'(os_q[j]), (j < 3) ? 32'd0 : 32'd1);
            end
            chk("both_idle_gap", 32'(cy_q[3] - cy_q[2]), 32'd2);
        end
        chk("both_tokdone", 32'(td_seen), 32'd2);
        chk("both_cnt0", 32'(bus.id_cnt0), 32'd1);
        chk("both_cnt1", 32'(bus.id_cnt1), 32'd1);

        // ---- source 0 goes silent mid-token while source 1 waits ----
        do_reset();
        xfer(0, 8'h61);
        bus.req1_valid = 1'b1; bus.req1_char = 8'h78;
        first_r1 = 0; td_seen = 0;
        for (cyc = 1; cyc <= 24; cyc++) begin
            if (bus.req1_ready && first_r1 == 0) first_r1 = cyc;
            @(posedge clk);
            #1;
            if (bus.tok_done) td_seen++;
        end
        bus.req1_valid = 1'b0;
`ifdef ID_ARB_TIMEOUT_EN
        chk("wd_grant_cycle", 32'(first_r1), 32'd18);
`else
        chk("wd_grant_cycle", 32'(first_r1), 32'd0);
`endif
        chk("wd_no_tokdone", 32'(td_seen), 32'd0);
        chk("wd_cnt0", 32'(bus.id_cnt0), 32'd0);

        // ---- reset while source 1 is inside token "ab" ----
        do_reset();
        xfer(1, 8'h61);
        xfer(1, 8'h62);
        chk("mid_out_valid_pre", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_out_char",  32'(bus.out_char),  32'd0);
        chk("mid_out_src",   32'(bus.out_src),   32'd0);
        chk("mid_tok_src",   32'(bus.tok_src),   32'd0);
        chk("mid_ready1",    32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_idle_after", 32'(bus.req1_ready), 32'd0);
        xfer(1, 8'h20);
        chk("mid_delim_fwd", 32'({bus.out_valid, bus.out_char}), 32'h120);
        chk("mid_no_tokdone", 32'(bus.tok_done), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_cnt1", 32'(bus.id_cnt1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_arbiter.md
ID_ARBITER -- requirements
Module: id_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, width of per-source identifier counters.
REQ-002 Parameter TMO_CYC, default 16, watchdog limit in cycles (used only with ID_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  source 0/1 presents a character.
REQ-006 req0_char / req1_char  input  8  ASCII character from source 0/1.
REQ-007 req0_ready / req1_ready  output  1  character accepted this cycle when valid&&ready.
REQ-008 out_valid  output  1  registered pulse: one accepted character forwarded.
REQ-009 out_char  output  8  forwarded character; out_src  output  1  its source.
REQ-010 tok_done  output  1  registered pulse: a token closed.
REQ-011 tok_is_id  output  1  closed token is an identifier; tok_src  output  1  its source.
REQ-012 id_cnt0 / id_cnt1  output  CNT_W  identifiers completed per source.

Function
REQ-013 Class: letter = 65..90 or 97..122; digit = 48..57; delimiter = any other value.
REQ-014 Token = maximal run of letters/digits from one source ended by an accepted delimiter; identifier = token whose first char is a letter.
REQ-015 FSM states IDLE, GRANT0, GRANT1; only one source granted at any time.
REQ-016 IDLE: no char accepted; both readys 0; next state chosen from valids sampled this cycle.
REQ-017 IDLE, one valid -> GRANT of that source; both valid -> source other than last_grant; none -> stay IDLE.
REQ-018 GRANTn: reqn_ready=1, other ready=0; grant held across idle cycles of source n until it delivers a delimiter.
REQ-019 Accepted delimiter in GRANTn -> IDLE next cycle; last_grant <= n.
REQ-020 Each accepted char (letter, digit or delimiter) -> out_valid=1, out_char, out_src exactly one cycle later.
REQ-021 Delimiter closing a token of length >=1 -> tok_done=1 with tok_is_id, tok_src one cycle after acceptance, same cycle as that delimiter's out_valid.
REQ-022 Delimiter with zero-length token -> grant released, no tok_done.
REQ-023 tok_is_id=1 -> id_cntn increments in same cycle as tok_done; saturates at 2^CNT_W-1.
REQ-024 tok_is_id / tok_src hold last values when tok_done=0; out_char / out_src hold when out_valid=0.
REQ-025 Token state (length-nonzero flag, first-char-letter flag) cleared on every grant change.

Reset
REQ-026 reset=1 asynchronously forces state IDLE, last_grant=1 (source 0 wins first tie).
REQ-027 reset forces out_valid, tok_done, tok_is_id, tok_src, out_src, id_cnt0, id_cnt1 to 0 and out_char to 8'h00.
REQ-028 Reset mid-token discards the token: no tok_done, no counter update; first cycle after release is IDLE.

Configuration
REQ-029 Macro ID_ARB_TIMEOUT_EN: when defined, a watchdog counts consecutive GRANTn cycles with reqn_valid=0.
REQ-030 With macro: count reaching TMO_CYC -> state IDLE next cycle, last_grant <= n, open token aborted (no tok_done, no count); counter cleared by any accepted char or grant change.
REQ-031 Without macro: no watchdog logic; grant held indefinitely; TMO_CYC unused.

Verification
REQ-032 Source 0 sends "a","1","b"," " -> out_valid x4 in order, one cycle after each accept; tok_done=1, tok_is_id=1, tok_src=0 with the " "; id_cnt0=1.
REQ-033 Source 1 sends "9","x","," -> tok_done=1, tok_is_id=0, tok_src=1; id_cnt1 stays 0.
REQ-034 Both valid from reset, each sending "ab " -> source 0 served first, IDLE cycle, then source 1; id_cnt0=1, id_cnt1=1; source-1 chars never interleaved into source-0 token.
REQ-035 Source 0 sends "  " (two delimiters) -> two out_valid pulses, no tok_done, counters unchanged.
REQ-036 Source 0 sends "a" then drops valid 20 cycles while source 1 valid: with ID_ARB_TIMEOUT_EN grant moves to source 1 after 16 idle cycles plus IDLE cycle, no tok_done for "a"; without macro source 1 stays stalled.
REQ-037 reset asserted while source 1 mid-token "ab" -> all outputs 0 immediately, no tok_done after release, id_cnt1=0.
